// File: rtl/cic_disp_pkg.sv
// Shared types and helpers for the CIC display path.
// Holds the converter FSM states and sizing functions.
package cic_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // ceil(width * log10(2)) + 1, in fixed point
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction.
// Adds 3 to a BCD digit of 5 or more ahead of the shift.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_blank.sv
// Iterative binary-to-BCD converter, one bit per clock.
// Adds sign handling, overflow marking and leading-zero blanking.
module bin2bcd_blank
  import cic_disp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  input  logic                  SIGN_IN,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     DIG_EN,
  output logic                  NEG,
  output logic                  OVF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int ACC_D = bcd_digits(WIDTH);
  localparam int EXT_D = (DIGITS > ACC_D) ? DIGITS : ACC_D;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [63:0] MAX_V = pow10(DIGITS) - 64'd1;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*ACC_D-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_int_q, neg_int_d;
  logic                  ovf_int_q, ovf_int_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     dig_en_q, dig_en_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4*ACC_D-1:0]    acc_adj;
  logic [4*EXT_D-1:0]    acc_ext;
  logic [DIGITS-1:0]     en_blank;
  logic [WIDTH-1:0]      mag_in;
  logic                  neg_in;
  logic                  ovf_in;
  logic                  any_nz;

  for (genvar i = 0; i < ACC_D; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[4*i +: 4]),
      .q (acc_adj[4*i +: 4])
    );
  end

  // Unsigned negate: the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    neg_in = SIGN_IN & BIN[WIDTH-1];
    mag_in = neg_in ? (~BIN + WIDTH'(1)) : BIN;
    ovf_in = 64'(mag_in) > MAX_V;
  end

  always_comb begin
    acc_ext = '0;
    acc_ext[4*ACC_D-1:0] = acc_q;
  end

  always_comb begin
    en_blank = '0;
    any_nz   = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz      = any_nz | (acc_ext[4*k +: 4] != 4'd0);
      en_blank[k] = any_nz | (k == 0);
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_int_d = neg_int_q;
    ovf_int_d = ovf_int_q;
    bcd_d     = bcd_q;
    dig_en_d  = dig_en_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = SHIFT;
          mag_d     = mag_in;
          neg_int_d = neg_in;
          ovf_int_d = ovf_in;
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        neg_d   = neg_int_q;
        ovf_d   = ovf_int_q;
        if (ovf_int_q) begin
          bcd_d    = {DIGITS{BCD_BLANK}};
          dig_en_d = '1;
        end else begin
          bcd_d    = acc_ext[4*DIGITS-1:0];
          dig_en_d = en_blank;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_int_q <= 1'b0;
      ovf_int_q <= 1'b0;
      bcd_q     <= '0;
      dig_en_q  <= DIGITS'(1);
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_int_q <= neg_int_d;
      ovf_int_q <= ovf_int_d;
      bcd_q     <= bcd_d;
      dig_en_q  <= dig_en_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BCD    = bcd_q;
  assign DIG_EN = dig_en_q;
  assign NEG    = neg_q;
  assign OVF    = ovf_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_bin2bcd_blank.sv
// Directed bench for bin2bcd_blank.
// Runs a 5-digit and a 4-digit instance side by side.
module tb_bin2bcd_blank;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] BIN = '0;
  logic        SIGN_IN = 1'b0;

  logic [19:0] bcd5;
  logic [4:0]  en5;
  logic        neg5, ovf5, busy5, done5;
  logic [15:0] bcd4;
  logic [3:0]  en4;
  logic        neg4, ovf4, busy4, done4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  bin2bcd_blank #(.WIDTH(16), .DIGITS(5)) u5 (
    .CLK (CLK), .RST_N (RST_N), .START (START),
    .BIN (BIN), .SIGN_IN (SIGN_IN),
    .BCD (bcd5), .DIG_EN (en5), .NEG (neg5),
    .OVF (ovf5), .BUSY (busy5), .DONE (done5)
  );

  bin2bcd_blank #(.WIDTH(16), .DIGITS(4)) u4 (
    .CLK (CLK), .RST_N (RST_N), .START (START),
    .BIN (BIN), .SIGN_IN (SIGN_IN),
    .BCD (bcd4), .DIG_EN (en4), .NEG (neg4),
    .OVF (ovf4), .BUSY (busy4), .DONE (done4)
  );

  // Pulse START for one edge, then count edges until DONE.
  task automatic run_conv(input logic [15:0] b, input logic s,
                          output int lat);
    @(posedge CLK); #1;
    BIN = b; SIGN_IN = s; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; BIN = 16'hA5A5; SIGN_IN = ~s;
    lat = 0;
    while (!done5 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (bcd5 !== 20'h0 || en5 !== 5'b00001) begin
      $display("FAIL reset_bcd5 got %h/%b want 00000/00001", bcd5, en5);
      n_bad++;
    end
    n_cmp++;
    if ({neg5, ovf5, busy5, done5} !== 4'b0) begin
      $display("FAIL reset_flags5 got %b want 0000",
               {neg5, ovf5, busy5, done5});
      n_bad++;
    end
    n_cmp++;
    if (bcd4 !== 16'h0 || en4 !== 4'b0001) begin
      $display("FAIL reset_bcd4 got %h/%b want 0000/0001", bcd4, en4);
      n_bad++;
    end
    RST_N = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat;
    run_conv(16'd12345, 1'b0, lat);
    n_cmp++;
    if (lat !== 17) begin
      $display("FAIL uns_latency got %0d want 17", lat);
      n_bad++;
    end
    n_cmp++;
    if (bcd5 !== 20'h12345 || en5 !== 5'b11111) begin
      $display("FAIL uns_bcd got %h/%b want 12345/11111", bcd5, en5);
      n_bad++;
    end
    n_cmp++;
    if ({neg5, ovf5, busy5} !== 3'b000) begin
      $display("FAIL uns_flags got %b want 000", {neg5, ovf5, busy5});
      n_bad++;
    end
    repeat (5) @(posedge CLK);
    #1;
    n_cmp++;
    if (bcd5 !== 20'h12345 || done5 !== 1'b0) begin
      $display("FAIL uns_hold got %h/%b want 12345/0", bcd5, done5);
      n_bad++;
    end
  endtask

  task automatic test_blank;
    int lat;
    run_conv(16'd0, 1'b0, lat);
    n_cmp++;
    if (bcd5 !== 20'h0 || en5 !== 5'b00001) begin
      $display("FAIL zero got %h/%b want 00000/00001", bcd5, en5);
      n_bad++;
    end
    run_conv(16'd42, 1'b0, lat);
    n_cmp++;
    if (bcd5 !== 20'h00042 || en5 !== 5'b00011) begin
      $display("FAIL blank42 got %h/%b want 00042/00011", bcd5, en5);
      n_bad++;
    end
    run_conv(16'd700, 1'b0, lat);
    n_cmp++;
    if (bcd5 !== 20'h00700 || en5 !== 5'b00111) begin
      $display("FAIL blank700 got %h/%b want 00700/00111", bcd5, en5);
      n_bad++;
    end
  endtask

  task automatic test_signed;
    int lat;
    run_conv(16'hFFD6, 1'b1, lat);
    n_cmp++;
    if (bcd5 !== 20'h00042 || en5 !== 5'b00011 || neg5 !== 1'b1) begin
      $display("FAIL neg42 got %h/%b/%b want 00042/00011/1",
               bcd5, en5, neg5);
      n_bad++;
    end
    run_conv(16'h8000, 1'b1, lat);
    n_cmp++;
    if (bcd5 !== 20'h32768 || neg5 !== 1'b1 || ovf5 !== 1'b0) begin
      $display("FAIL min_int got %h/%b/%b want 32768/1/0",
               bcd5, neg5, ovf5);
      n_bad++;
    end
    n_cmp++;
    if (bcd4 !== 16'hFFFF || ovf4 !== 1'b1 || neg4 !== 1'b1) begin
      $display("FAIL min_int4 got %h/%b/%b want FFFF/1/1",
               bcd4, ovf4, neg4);
      n_bad++;
    end
    run_conv(16'hFFD6, 1'b0, lat);
    n_cmp++;
    if (bcd5 !== 20'h65494 || neg5 !== 1'b0) begin
      $display("FAIL uns_ffd6 got %h/%b want 65494/0", bcd5, neg5);
      n_bad++;
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_conv(16'd10000, 1'b0, lat);
    n_cmp++;
    if (bcd4 !== 16'hFFFF || en4 !== 4'b1111 || ovf4 !== 1'b1) begin
      $display("FAIL ovf4 got %h/%b/%b want FFFF/1111/1",
               bcd4, en4, ovf4);
      n_bad++;
    end
    n_cmp++;
    if (bcd5 !== 20'h10000 || ovf5 !== 1'b0) begin
      $display("FAIL ovf5 got %h/%b want 10000/0", bcd5, ovf5);
      n_bad++;
    end
    run_conv(16'd9999, 1'b0, lat);
    n_cmp++;
    if (bcd4 !== 16'h9999 || en4 !== 4'b1111 || ovf4 !== 1'b0) begin
      $display("FAIL max4 got %h/%b/%b want 9999/1111/0",
               bcd4, en4, ovf4);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back;
    int n_done;
    int t1, t2;
    logic [19:0] r1, r2;
    n_done = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    @(posedge CLK); #1;
    BIN = 16'd100; SIGN_IN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    BIN = 16'd7;
    for (int c = 1; c <= 45; c++) begin
      @(posedge CLK); #1;
      if (done5) begin
        n_done++;
        if (n_done == 1) begin t1 = c; r1 = bcd5; end
        if (n_done == 2) begin t2 = c; r2 = bcd5; end
      end
      if (c == 18) START = 1'b0;
    end
    n_cmp++;
    if (n_done !== 2) begin
      $display("FAIL b2b_count got %0d want 2", n_done);
      n_bad++;
    end
    n_cmp++;
    if (t1 !== 17 || r1 !== 20'h00100) begin
      $display("FAIL b2b_first got t=%0d %h want t=17 00100", t1, r1);
      n_bad++;
    end
    n_cmp++;
    if (t2 !== 35 || r2 !== 20'h00007) begin
      $display("FAIL b2b_second got t=%0d %h want t=35 00007", t2, r2);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int n_done;
    @(posedge CLK); #1;
    BIN = 16'd12345; SIGN_IN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (bcd5 !== 20'h0 || en5 !== 5'b00001 || busy5 !== 1'b0) begin
      $display("FAIL mid_reset got %h/%b/%b want 00000/00001/0",
               bcd5, en5, busy5);
      n_bad++;
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      if (done5) n_done++;
    end
    n_cmp++;
    if (n_done !== 0 || busy5 !== 1'b0) begin
      $display("FAIL mid_no_done got %0d/%b want 0/0", n_done, busy5);
      n_bad++;
    end
    run_conv(16'd255, 1'b0, lat);
    n_cmp++;
    if (lat !== 17 || bcd5 !== 20'h00255 || en5 !== 5'b00111) begin
      $display("FAIL mid_restart got %0d/%h/%b want 17/00255/00111",
               lat, bcd5, en5);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_blank();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_blank.md
Name: bin2bcd_blank

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3), one bit per clock.
- Adds optional two's-complement sign handling and leading-zero blanking.
- Sits between the CIC decimator output register and the per-digit BCD-to-7-segment decoders.
- Each BCD nibble drives one decoder's 4-bit digit input; each DIG_EN bit drives that decoder's enable.
- NEG drives a separate minus-sign indicator.

Parameters:
- WIDTH, 16, bit width of BIN; legal range 4..32.
- DIGITS, 5, number of BCD digits produced; legal range 1..10.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  conversion request; sampled only in IDLE.
- BIN  in  WIDTH  value to convert; captured on the accepting edge.
- SIGN_IN  in  1  1 = treat BIN as two's complement; captured with BIN.
- BCD  out  4*DIGITS  digit k at bits [4k+3:4k]; digit 0 is least significant.
- DIG_EN  out  DIGITS  per-digit enable; 0 = blank (leading zero).
- NEG  out  1  result was negative.
- OVF  out  1  magnitude exceeds 10^DIGITS-1.
- BUSY  out  1  conversion in progress.
- DONE  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - BCD = 0, DIG_EN = {{DIGITS-1{0}},1}, NEG = 0, OVF = 0, BUSY = 0, DONE = 0.
  - Any in-flight conversion is discarded; no DONE follows it.
- FSM states:
  - IDLE to SHIFT on START.
  - SHIFT to SHIFT while bit counter < WIDTH-1.
  - SHIFT to FINISH on the last bit.
  - FINISH to IDLE unconditionally.
- Capture edge (IDLE with START=1):
  - MAG = (SIGN_IN && BIN[WIDTH-1]) ? -BIN : BIN, computed as an unsigned WIDTH-bit value.
  - -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) with no wrap, because MAG is unsigned.
  - Latch NEG_int = SIGN_IN & BIN[WIDTH-1].
  - Latch OVF_int = (MAG > 10^DIGITS-1).
  - Clear the internal BCD accumulator and the bit counter. BUSY = 1 from the next cycle.
- SHIFT, one bit per cycle, MSB first:
  - Every accumulator nibble >= 5 gets +3.
  - Then shift {acc, mag} left by 1.
  - The internal accumulator has enough digits for WIDTH bits, ceil(WIDTH*0.30103)+1, independent of DIGITS.
- FINISH edge:
  - Register BCD from the low DIGITS digits of the accumulator; update NEG, OVF and DIG_EN.
  - DONE = 1 for exactly one cycle; BUSY = 0 in that same cycle.
- Latency:
  - START sampled at edge 0 gives DONE high in the cycle after edge WIDTH+1.
  - With WIDTH=16, that is 17 cycles.
  - Outputs hold their value until the next FINISH.
- Blanking:
  - DIG_EN[k] = 1 if any digit j >= k is nonzero, or k == 0.
  - A value of 0 therefore shows a single "0".
- Overflow:
  - OVF = 1, all BCD nibbles = 4'hF, DIG_EN = all ones.
  - Each downstream decoder blanks on 4'hF.
  - NEG still reflects the sign.
- START handling:
  - START while BUSY is ignored, with no queuing.
  - START in the DONE cycle is accepted, since the state is already IDLE; the next conversion begins back-to-back.
- BIN and SIGN_IN are don't-care except on the capture edge.

Decomposition:
- Package cic_disp_pkg holds:
  - the state enum {IDLE, SHIFT, FINISH};
  - localparam BCD_BLANK = 4'hF;
  - function pow10(n) returning a 64-bit value, used for the overflow threshold;
  - function bcd_digits(width) returning the internal accumulator digit count.
- Sub-module bcd_digit_adj: combinational 4-bit "if >= 5 add 3", instantiated per accumulator digit with a generate loop.
- Blanking is an in-module loop on the FINISH edge; no separate module.

Test Plan:
- Case 1, unsigned value:
  - Stimulus: WIDTH=16, DIGITS=5, BIN=12345, SIGN_IN=0, START pulse.
  - Response: DONE exactly 17 cycles after the START edge; BCD=20'h12345, DIG_EN=5'b11111, NEG=0, OVF=0.
- Case 2, zero and leading-zero blanking:
  - Stimulus: BIN=0, then BIN=42.
  - Response: BCD=0 with DIG_EN=5'b00001; then BCD=20'h00042 with DIG_EN=5'b00011.
- Case 3, signed inputs:
  - Stimulus: SIGN_IN=1 with BIN=16'hFFD6 (-42), then BIN=16'h8000.
  - Response: for -42, BCD=20'h00042, NEG=1, DIG_EN=5'b00011. For 16'h8000, BCD=20'h32768, NEG=1, OVF=0.
- Case 4, overflow:
  - Stimulus: DIGITS=4 build, BIN=16'd10000, SIGN_IN=0.
  - Response: OVF=1, BCD=16'hFFFF, DIG_EN=4'b1111. Repeat with BIN=9999: OVF=0, BCD=16'h9999.
- Case 5, START handling:
  - Stimulus: START held high while BUSY; also START asserted in the DONE cycle.
  - Response: no restart while BUSY; a single DONE per conversion; the second conversion's DONE lands 17 cycles after the DONE-cycle START.
- Case 6, reset mid-conversion:
  - Stimulus: RST_N low at cycle 8 of a conversion, with no clock edge needed.
  - Response: outputs go to reset values immediately; no DONE afterwards. A new START converts correctly.
